// File: rtl/prover_compute_w0_pkg.sv
// Shared types and constants for the parallel w0 evaluator.
// Field width/modulus come from `F_NBITS / `F_Q; defaults here are the
// Mersenne prime 2^61-1 when the field defs have not been included first.
// Optional build macro used by the top: PROVER_COMPUTE_W0_TAU0_BYPASS_EN.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

package prover_compute_w0_pkg;

    localparam int F_NBITS = `F_NBITS;
    localparam logic [F_NBITS-1:0] F_Q = `F_Q;

    // Cycles from element en to element ready (results valid).
    localparam int ELEM_LAT = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DONE
    } w0_state_t;

    function automatic int nbatch_f(input int n, input int l);
        return (n + l - 1) / l;
    endfunction

    function automatic int bcnt_w(input int nb);
        return (nb <= 2) ? 1 : $clog2(nb);
    endfunction

    // 1 - a (mod p) for canonical a, result canonical.
    function automatic logic [F_NBITS-1:0] f_one_minus(input logic [F_NBITS-1:0] a);
        if (a <= F_NBITS'(1)) return F_NBITS'(1) - a;
        return F_Q - a + F_NBITS'(1);
    endfunction

endpackage

// File: rtl/prover_compute_w0_elem.sv
// One element unit: w0 = w2_m_w1*tau + w1 (mod p) and m_w0_p1 = 1 - w0.
// ready = idle & ~en; ready returns ELEM_LAT cycles after en and the
// result registers hold until the next en.
module prover_compute_w0_elem
    import prover_compute_w0_pkg::*;
(
    input  logic               clk,
    input  logic               rstb,
    input  logic               en,
    input  logic [F_NBITS-1:0] w1,
    input  logic [F_NBITS-1:0] w2_m_w1,
    input  logic [F_NBITS-1:0] tau,
    output logic               ready,
    output logic [F_NBITS-1:0] w0,
    output logic [F_NBITS-1:0] m_w0_p1
);

    localparam int PW = 2 * F_NBITS;

    logic               vld_p0, vld_p1;
    logic [PW-1:0]      prod_p0;
    logic [F_NBITS-1:0] w1_p0;
    logic [F_NBITS-1:0] pmod_p1, w1_p1;
    logic [F_NBITS-1:0] w0_p2, m_p2;
    logic [F_NBITS-1:0] sum_p1;

    function automatic logic [F_NBITS-1:0] f_reduce(input logic [PW-1:0] x);
        return F_NBITS'(x % PW'(F_Q));
    endfunction

    function automatic logic [F_NBITS-1:0] f_add(input logic [F_NBITS-1:0] a,
                                                 input logic [F_NBITS-1:0] b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
        return s[F_NBITS-1:0];
    endfunction

    assign sum_p1  = f_add(pmod_p1, w1_p1);
    assign ready   = ~vld_p0 & ~vld_p1 & ~en;
    assign w0      = w0_p2;
    assign m_w0_p1 = m_p2;

    // Valid bits track the element through the pipeline.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= en;
            vld_p1 <= vld_p0;
        end
    end

    // Datapath registers, advanced only by their stage valid.
    always_ff @(posedge clk) begin
        // p0: raw product
        if (en) begin
            prod_p0 <= PW'(w2_m_w1) * PW'(tau);
            w1_p0   <= w1;
        end
        // p1: product reduced mod p
        if (vld_p0) begin
            pmod_p1 <= f_reduce(prod_p0);
            w1_p1   <= w1_p0;
        end
        // p2: final sum and its complement, held until next en
        if (vld_p1) begin
            w0_p2 <= sum_p1;
            m_p2  <= f_one_minus(sum_p1);
        end
    end

endmodule

// File: rtl/prover_compute_w0_par.sv
// Parallel w0 evaluator: evaluates all ninbits elements in batches of
// nlanes element units after a single start, then pulses done.
// Build option PROVER_COMPUTE_W0_TAU0_BYPASS_EN: with tau==0 each batch
// copies w1 straight through in its LAUNCH cycle instead of using lanes.
module prover_compute_w0_par
    import prover_compute_w0_pkg::*;
#(
    parameter int ninbits = 3,
    parameter int nlanes  = 2
)
(
    input  logic               clk,
    input  logic               rstb,
    input  logic               en,
    input  logic [F_NBITS-1:0] w1      [ninbits],
    input  logic [F_NBITS-1:0] w2_m_w1 [ninbits],
    input  logic [F_NBITS-1:0] tau,
    output logic               ready,
    output logic               done,
    output logic [F_NBITS-1:0] w0      [ninbits],
    output logic [F_NBITS-1:0] m_w0_p1 [ninbits]
);

    localparam int NBATCH = nbatch_f(ninbits, nlanes);
    localparam int BW     = bcnt_w(NBATCH);
    localparam logic [BW-1:0] BLAST = BW'(NBATCH - 1);

    w0_state_t          state;
    logic               en_dly, start, byp, all_rdy;
    logic [BW-1:0]      batch;
    logic [F_NBITS-1:0] tau_reg;

    logic [nlanes-1:0]  lane_act, lane_en, lane_rdy;
    logic [F_NBITS-1:0] lane_w1 [nlanes];
    logic [F_NBITS-1:0] lane_w2 [nlanes];
    logic [F_NBITS-1:0] lane_w0 [nlanes];
    logic [F_NBITS-1:0] lane_m  [nlanes];

    logic [ninbits-1:0] wr_el;
    logic [F_NBITS-1:0] wr_w0 [ninbits];
    logic [F_NBITS-1:0] wr_m  [ninbits];

    assign start   = en & ~en_dly;
    assign ready   = (state == ST_IDLE) & ~start;
    assign all_rdy = &(lane_rdy | ~lane_act);

`ifdef PROVER_COMPUTE_W0_TAU0_BYPASS_EN
    assign byp = (tau_reg == '0);
`else
    assign byp = 1'b0;
`endif

    // Route the current batch's elements onto the lanes; lanes past the end are idle.
    always_comb begin
        for (int k = 0; k < nlanes; k++) begin
            lane_act[k] = 1'b0;
            lane_w1[k]  = '0;
            lane_w2[k]  = '0;
            for (int e = 0; e < ninbits; e++) begin
                if (e == int'(batch) * nlanes + k) begin
                    lane_act[k] = 1'b1;
                    lane_w1[k]  = w1[e];
                    lane_w2[k]  = w2_m_w1[e];
                end
            end
            lane_en[k] = (state == ST_LAUNCH) & lane_act[k] & ~byp;
        end
    end

    // Select which element slots are written this cycle and with what.
    always_comb begin
        for (int e = 0; e < ninbits; e++) begin
            wr_el[e] = 1'b0;
            wr_w0[e] = '0;
            wr_m[e]  = '0;
            for (int k = 0; k < nlanes; k++) begin
                if (e == int'(batch) * nlanes + k) begin
                    if (state == ST_RUN && all_rdy) begin
                        wr_el[e] = 1'b1;
                        wr_w0[e] = lane_w0[k];
                        wr_m[e]  = lane_m[k];
                    end else if (state == ST_LAUNCH && byp) begin
                        wr_el[e] = 1'b1;
                        wr_w0[e] = lane_w1[k];
                        wr_m[e]  = f_one_minus(lane_w1[k]);
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < nlanes; k++) begin : g_lane
        if (k < ninbits) begin : g_act
            prover_compute_w0_elem u_elem (
                .clk     (clk),
                .rstb    (rstb),
                .en      (lane_en[k]),
                .w1      (lane_w1[k]),
                .w2_m_w1 (lane_w2[k]),
                .tau     (tau_reg),
                .ready   (lane_rdy[k]),
                .w0      (lane_w0[k]),
                .m_w0_p1 (lane_m[k])
            );
        end else begin : g_off
            assign lane_rdy[k] = 1'b1;
            assign lane_w0[k]  = '0;
            assign lane_m[k]   = '0;
        end
    end

    // Challenge captured once per run so tau may move after start.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) tau_reg <= tau;
    end

    // Batch sequencer with registered done pulse.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state  <= ST_IDLE;
            en_dly <= 1'b1;
            batch  <= '0;
            done   <= 1'b0;
        end else begin
            en_dly <= en;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        batch <= '0;
                        state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (!byp) begin
                        state <= ST_RUN;
                    end else if (batch == BLAST) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        batch <= batch + BW'(1);
                    end
                end
                ST_RUN: begin
                    if (all_rdy) begin
                        if (batch == BLAST) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            batch <= batch + BW'(1);
                            state <= ST_LAUNCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result slots keep their value until their batch rewrites them.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int e = 0; e < ninbits; e++) begin
                w0[e]      <= '0;
                m_w0_p1[e] <= '0;
            end
        end else begin
            for (int e = 0; e < ninbits; e++) begin
                if (wr_el[e]) begin
                    w0[e]      <= wr_w0[e];
                    m_w0_p1[e] <= wr_m[e];
                end
            end
        end
    end

endmodule

// File: tb/tb_prover_compute_w0_par.sv
// Bench for prover_compute_w0_par: two instances (2 lanes and 3 lanes)
// share stimulus; a per-instance queue holds expected results and latency.
module tb_prover_compute_w0_par;
    import prover_compute_w0_pkg::*;

    localparam int W = F_NBITS;
    localparam logic [W-1:0] P = F_Q;
    localparam int N = 3;
    localparam int L = 3;
`ifdef PROVER_COMPUTE_W0_TAU0_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0][W-1:0] w0;
        logic [N-1:0][W-1:0] m;
        int                  t0;
        int                  lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rstb, en;
    logic [W-1:0] w1 [N];
    logic [W-1:0] w2 [N];
    logic [W-1:0] tau;
    logic         rdy_a, done_a, rdy_b, done_b;
    logic [W-1:0] w0_a [N];
    logic [W-1:0] m_a  [N];
    logic [W-1:0] w0_b [N];
    logic [W-1:0] m_b  [N];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    prover_compute_w0_par #(.ninbits(3), .nlanes(2)) u_dut_a (
        .clk(clk), .rstb(rstb), .en(en), .w1(w1), .w2_m_w1(w2), .tau(tau),
        .ready(rdy_a), .done(done_a), .w0(w0_a), .m_w0_p1(m_a)
    );

    prover_compute_w0_par #(.ninbits(3), .nlanes(3)) u_dut_b (
        .clk(clk), .rstb(rstb), .en(en), .w1(w1), .w2_m_w1(w2), .tau(tau),
        .ready(rdy_b), .done(done_b), .w0(w0_b), .m_w0_p1(m_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mdl_w0(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] t);
        logic [127:0] x;
        x = 128'(a) * 128'(t) + 128'(b);
        return W'(x % 128'(P));
    endfunction

    function automatic logic [W-1:0] mdl_m(input logic [W-1:0] v);
        logic [127:0] x;
        x = (128'(P) + 128'(1) - 128'(v)) % 128'(P);
        return W'(x);
    endfunction

    function automatic int lat_of(input int nb, input logic t0);
        return (BYP && t0) ? nb + 1 : nb * (L + 1) + 1;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [63:0] x;
        x = {$urandom, $urandom};
        return W'(x % 64'(P));
    endfunction

    task automatic score(input string nm, input exp_t e,
                         input logic [W-1:0] g0 [N], input logic [W-1:0] gm [N]);
        chk($sformatf("%s_latency", nm), 128'(cyc - e.t0), 128'(e.lat));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_w0[%0d]", nm, i), g0[i], e.w0[i]);
            chk($sformatf("%s_m_w0_p1[%0d]", nm, i), gm[i], e.m[i]);
        end
    endtask

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (rstb && done_a) begin
            chk("a_ready_during_done", rdy_a, 0);
            if (q_a.size() == 0) chk("a_unexpected_done", done_a, 0);
            else score("a", q_a.pop_front(), w0_a, m_a);
        end
        if (rstb && done_b) begin
            chk("b_ready_during_done", rdy_b, 0);
            if (q_b.size() == 0) chk("b_unexpected_done", done_b, 0);
            else score("b", q_b.pop_front(), w0_b, m_b);
        end
    end

    // Push expectations from current inputs, then give en a one-cycle rising edge.
    task automatic launch();
        exp_t ea, eb;
        logic t0;
        t0 = (tau == '0);
        for (int i = 0; i < N; i++) begin
            ea.w0[i] = mdl_w0(w2[i], w1[i], tau);
            ea.m[i]  = mdl_m(ea.w0[i]);
        end
        eb = ea;
        ea.t0 = cyc;
        eb.t0 = cyc;
        ea.lat = lat_of(2, t0);
        eb.lat = lat_of(1, t0);
        q_a.push_back(ea);
        q_b.push_back(eb);
        en = 1'b1;
        @(posedge clk); #1;
        en  = 1'b0;
        tau = rnd();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(q_a.size() == 0 && q_b.size() == 0 && rdy_a && rdy_b) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_complete"}, 128'(n < 60), 1);
        if (n >= 60) begin
            q_a.delete();
            q_b.delete();
        end
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < N; i++) begin
            w1[i] = rnd();
            w2[i] = rnd();
        end
        tau = rnd();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb = 1'b0;
        en   = 1'b1;
        tau  = '0;
        for (int i = 0; i < N; i++) begin
            w1[i] = '0;
            w2[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_a", rdy_a, 1);
        chk("rst_ready_b", rdy_b, 1);
        chk("rst_done_a", done_a, 0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_w0_a[%0d]", i), w0_a[i], 0);
            chk($sformatf("rst_m_a[%0d]", i), m_a[i], 0);
        end

        // en held high across reset release must not start a run
        rstb = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("en_held_ready_a", rdy_a, 1);
        chk("en_held_ready_b", rdy_b, 1);
        chk("en_held_w0_a0", w0_a[0], 0);
        en = 1'b0;
        @(posedge clk); #1;

        // reference vectors
        w1  = '{61'd3, 61'd10, 61'd0};
        w2  = '{61'd5, 61'd1, P - 61'd1};
        tau = 61'd7;
        launch();
        wait_idle("tp1");
        chk("tp1_w0_0", w0_a[0], 38);
        chk("tp1_w0_1", w0_a[1], 17);
        chk("tp1_w0_2", w0_a[2], P - 61'd7);
        chk("tp1_m_0", m_a[0], P - 61'd37);
        chk("tp1_m_1", m_a[1], P - 61'd16);
        chk("tp1_m_2", m_b[2], 8);

        // second rising edge during RUN is ignored
        rand_inputs();
        launch();
        @(posedge clk); #1;
        en = 1'b1;
        wait_idle("dbl_edge");
        repeat (12) @(posedge clk);
        #1;
        chk("dbl_edge_ready_a", rdy_a, 1);
        en = 1'b0;
        @(posedge clk); #1;

        // tau == 0
        w1  = '{61'd0, 61'd1, 61'd5};
        w2  = '{rnd(), rnd(), rnd()};
        tau = '0;
        launch();
        wait_idle("tau0");
        chk("tau0_w0_2", w0_b[2], 5);
        chk("tau0_m_0", m_a[0], 1);
        chk("tau0_m_1", m_a[1], 0);
        chk("tau0_m_2", m_a[2], P - 61'd4);

        // ordinary random run
        rand_inputs();
        launch();
        wait_idle("rand1");

        // reset in the middle of RUN
        rand_inputs();
        launch();
        @(posedge clk);
        #2;
        rstb = 1'b0;
        #1;
        chk("midrst_ready_a", rdy_a, 1);
        chk("midrst_ready_b", rdy_b, 1);
        chk("midrst_done_a", done_a, 0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("midrst_w0_a[%0d]", i), w0_a[i], 0);
            chk($sformatf("midrst_m_b[%0d]", i), m_b[i], 0);
        end
        q_a.delete();
        q_b.delete();
        @(posedge clk); #1;
        rstb = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < 2; r++) begin
            rand_inputs();
            launch();
            wait_idle($sformatf("post_rst%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
